// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control FSM: opcodes, state encoding,
// decoded instruction classes and the alu_op / wb_sel encodings.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_JUMP  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_DM  = 1'b1;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP   = 3'd0,
        CLS_ADD   = 3'd1,
        CLS_SUB   = 3'd2,
        CLS_LOAD  = 3'd3,
        CLS_STORE = 3'd4,
        CLS_JUMP  = 3'd5,
        CLS_HALT  = 3'd6
    } op_class_t;

    // Any opcode not listed here behaves as a NOP.
    function automatic op_class_t classify(input logic [3:0] op);
        case (op)
            OP_ADD:   return CLS_ADD;
            OP_SUB:   return CLS_SUB;
            OP_LOAD:  return CLS_LOAD;
            OP_STORE: return CLS_STORE;
            OP_JUMP:  return CLS_JUMP;
            OP_HALT:  return CLS_HALT;
            default:  return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decoder: splits the latched IR into its class
// and operand fields. Fields are extracted unconditionally; the FSM only
// uses the ones meaningful for the current class.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [15:0]     ir,
    output op_class_t       op_class,
    output logic [3:0]      rd,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [7:0]      addr,
    output logic [PC_W-1:0] target
);

    // Field extraction; rd doubles as the source register of a STORE.
    always_comb begin
        op_class = classify(ir[15:12]);
        rd       = ir[11:8];
        rs1      = ir[7:4];
        rs2      = ir[3:0];
        addr     = ir[7:0];
        target   = ir[PC_W-1:0];
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control FSM: FETCH -> DECODE -> {EXEC -> WB | MEM [-> WB]
// | HALT}. Outputs are decoded from the current state and the latched IR.
// Optional retired-instruction counter enabled by CPU_CTRL_PERF_CNT_EN;
// without it retired_count is a constant zero.
// Data-memory handshake: dm_req rises in MEM and stays high with dm_we and
// dm_addr stable until dm_ready is sampled high on a rising clk edge; that
// edge completes the transfer. dm_ready is ignored in every other state.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DM_AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instruction,
    input  logic             dm_ready,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_target,
    output logic [3:0]       rf_raddr1,
    output logic [3:0]       rf_raddr2,
    output logic [3:0]       rf_waddr,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             alu_op,
    output logic             dm_req,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic             halted,
    output logic [31:0]      retired_count,
    output state_t           state_dbg
);

    state_t          state;
    state_t          state_nx;
    logic [15:0]     ir;
    op_class_t       op_class;
    logic [3:0]      rd;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [7:0]      addr;
    logic [PC_W-1:0] target;

    cpu_ctrl_decode #(
        .PC_W (PC_W)
    ) u_decode (
        .ir       (ir),
        .op_class (op_class),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .addr     (addr),
        .target   (target)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Instruction register: captures the IM output during FETCH only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (state == ST_FETCH) begin
            ir <= instruction;
        end
    end

    // Next-state and output decode; everything is forced low while reset
    // is asserted so outputs clear in the same time step as the reset.
    always_comb begin
        state_nx  = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rf_waddr  = '0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        alu_op    = ALU_ADD;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        halted    = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    pc_inc   = 1'b1;
                    state_nx = ST_DECODE;
                end
                ST_DECODE: begin
                    case (op_class)
                        CLS_ADD, CLS_SUB:    state_nx = ST_EXEC;
                        CLS_LOAD, CLS_STORE: state_nx = ST_MEM;
                        CLS_HALT:            state_nx = ST_HALT;
                        CLS_JUMP: begin
                            pc_load   = 1'b1;
                            pc_target = target;
                            state_nx  = ST_FETCH;
                        end
                        default:             state_nx = ST_FETCH;
                    endcase
                end
                ST_EXEC: begin
                    rf_raddr1 = rs1;
                    rf_raddr2 = rs2;
                    alu_op    = (op_class == CLS_SUB) ? ALU_SUB : ALU_ADD;
                    state_nx  = ST_WB;
                end
                ST_MEM: begin
                    dm_req  = 1'b1;
                    dm_we   = (op_class == CLS_STORE);
                    dm_addr = DM_AW'(addr);
                    if (op_class == CLS_STORE) begin
                        rf_raddr1 = rd;
                    end
                    if (dm_ready) begin
                        state_nx = (op_class == CLS_STORE) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd;
                    if (op_class == CLS_LOAD) begin
                        wb_sel = WB_DM;
                    end else begin
                        rf_raddr1 = rs1;
                        rf_raddr2 = rs2;
                        alu_op    = (op_class == CLS_SUB) ? ALU_SUB : ALU_ADD;
                    end
                    state_nx = ST_FETCH;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    state_nx = ST_FETCH;
                end
            endcase
        end
    end

    assign state_dbg = state;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic        retire;
    logic [31:0] ret_cnt;

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire = 1'b0;
        if (!reset) begin
            case (state)
                ST_WB:     retire = 1'b1;
                ST_MEM:    retire = (op_class == CLS_STORE) && dm_ready;
                ST_DECODE: retire = (op_class == CLS_JUMP) || (op_class == CLS_NOP);
                default:   retire = 1'b0;
            endcase
        end
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_cnt <= '0;
        end else if (retire && (ret_cnt != 32'hFFFF_FFFF)) begin
            ret_cnt <= ret_cnt + 32'd1;
        end
    end

    assign retired_count = ret_cnt;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: a table of per-cycle vectors for the documented
// instruction scenarios, hand-written reset/HALT sequences, and a random
// instruction stream checked against a per-instruction trace model.
module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    localparam logic [15:0] JUNK = 16'hF000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = '0;
    logic        dm_ready = 1'b0;
    logic        pc_inc, pc_load, rf_we, wb_sel, alu_op;
    logic        dm_req, dm_we, halted;
    logic [7:0]  pc_target, dm_addr;
    logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] retired_count;
    state_t      state_dbg;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.PC_W(8), .DM_AW(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .dm_ready      (dm_ready),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .pc_target     (pc_target),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_waddr      (rf_waddr),
        .rf_we         (rf_we),
        .wb_sel        (wb_sel),
        .alu_op        (alu_op),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .halted        (halted),
        .retired_count (retired_count),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard types ----------------
    typedef struct packed {
        logic        pc_inc;
        logic        pc_load;
        logic [7:0]  pc_target;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa;
        logic        rf_we;
        logic        wb_sel;
        logic        alu_op;
        logic        dm_req;
        logic        dm_we;
        logic [7:0]  dm_addr;
        logic        halted;
        logic [31:0] ret;
    } outs_t;

    // en = {pc_inc, pc_load, rf_we, dm_req}; ta is pc_target or dm_addr.
    typedef struct {
        logic [15:0] instr;
        logic        rdy;
        logic [3:0]  en;
        logic [7:0]  ta;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [3:0]  wa;
        logic        alu;
        logic        wsel;
        logic        dwe;
        int          ret;
    } vec_t;

    int    n_checks = 0;
    int    n_err    = 0;
    int    n_ret    = 0;
    vec_t  vt[$];

    function automatic logic [31:0] retv(input int n);
`ifdef CPU_CTRL_PERF_CNT_EN
        return 32'(n);
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.pc_inc = pc_inc;   s.pc_load = pc_load; s.pc_target = pc_target;
        s.ra1 = rf_raddr1;   s.ra2 = rf_raddr2;   s.wa = rf_waddr;
        s.rf_we = rf_we;     s.wb_sel = wb_sel;   s.alu_op = alu_op;
        s.dm_req = dm_req;   s.dm_we = dm_we;     s.dm_addr = dm_addr;
        s.halted = halted;   s.ret = retired_count;
        return s;
    endfunction

    function automatic vec_t mkv(input logic [15:0] instr, input logic rdy,
                                 input logic [3:0] en, input logic [7:0] ta,
                                 input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [3:0] wa, input logic alu,
                                 input logic wsel, input logic dwe, input int ret);
        vec_t v;
        v.instr = instr; v.rdy = rdy; v.en = en; v.ta = ta; v.a1 = a1;
        v.a2 = a2; v.wa = wa; v.alu = alu; v.wsel = wsel; v.dwe = dwe; v.ret = ret;
        return v;
    endfunction

    function automatic outs_t to_outs(input vec_t v);
        outs_t e = '0;
        e.pc_inc  = v.en[3];
        e.pc_load = v.en[2];
        e.rf_we   = v.en[1];
        e.dm_req  = v.en[0];
        if (v.en[2]) e.pc_target = v.ta;
        if (v.en[0]) e.dm_addr = v.ta;
        e.ra1 = v.a1; e.ra2 = v.a2; e.wa = v.wa;
        e.alu_op = v.alu; e.wb_sel = v.wsel; e.dm_we = v.dwe;
        e.ret = retv(v.ret);
        return e;
    endfunction

    // ---------------- driver / checker tasks ----------------
    // Inputs are set by the caller just after a rising edge; outputs are
    // compared on the falling edge of the same cycle.
    task automatic check_cycle(input outs_t exp, input string tag);
        outs_t got;
        @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input logic got, input logic exp, input string tag);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instruction = '0;
        dm_ready = 1'b0;
        @(negedge clk);
        check_cycle_now('0, "reset_outputs");
        check_bit(state_dbg == ST_FETCH, 1'b1, "reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_ret = 0;
    endtask

    task automatic check_cycle_now(input outs_t exp, input string tag);
        outs_t got;
        got = sample();
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: expands one instruction into its expected cycle
    // trace straight from the instruction format, driving a random
    // dm_ready each cycle and junk on the instruction bus after FETCH.
    task automatic run_instr(input logic [15:0] ins, input int halt_cycles);
        outs_t e;
        logic [3:0] op = ins[15:12];
        int lows;
        instruction = ins;
        dm_ready = 1'($urandom);
        e = '0; e.pc_inc = 1'b1; e.ret = retv(n_ret);
        check_cycle(e, $sformatf("fetch %h", ins));
        instruction = 16'($urandom);
        dm_ready = 1'($urandom);
        e = '0; e.ret = retv(n_ret);
        if (op == 4'h4) begin
            e.pc_load = 1'b1;
            e.pc_target = ins[7:0];
        end
        check_cycle(e, $sformatf("decode %h", ins));
        if (op == 4'h0 || op == 4'h1) begin
            e = '0; e.ra1 = ins[7:4]; e.ra2 = ins[3:0]; e.alu_op = op[0];
            e.ret = retv(n_ret);
            dm_ready = 1'($urandom);
            check_cycle(e, $sformatf("exec %h", ins));
            e.rf_we = 1'b1; e.wa = ins[11:8]; e.wb_sel = 1'b0;
            dm_ready = 1'($urandom);
            check_cycle(e, $sformatf("wb %h", ins));
            n_ret++;
        end else if (op == 4'h2 || op == 4'h3) begin
            lows = $urandom_range(0, 3);
            for (int i = 0; i <= lows; i++) begin
                instruction = 16'($urandom);
                dm_ready = (i == lows);
                e = '0; e.dm_req = 1'b1; e.dm_we = (op == 4'h3);
                e.dm_addr = ins[7:0];
                e.ra1 = (op == 4'h3) ? ins[11:8] : 4'h0;
                e.ret = retv(n_ret);
                check_cycle(e, $sformatf("mem%0d %h", i, ins));
            end
            if (op == 4'h2) begin
                dm_ready = 1'($urandom);
                e = '0; e.rf_we = 1'b1; e.wa = ins[11:8]; e.wb_sel = 1'b1;
                e.ret = retv(n_ret);
                check_cycle(e, $sformatf("wb %h", ins));
            end
            n_ret++;
        end else if (op == 4'hF) begin
            for (int k = 0; k < halt_cycles; k++) begin
                instruction = 16'($urandom);
                dm_ready = 1'($urandom);
                e = '0; e.halted = 1'b1; e.ret = retv(n_ret);
                check_cycle(e, $sformatf("halt%0d", k));
            end
        end else begin
            n_ret++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        outs_t e;
        logic [15:0] ins;
        int pick;

        // Per-cycle vector table for the documented scenarios.
        // ADD r3 = r1 + r2
        vt.push_back(mkv(16'h0312, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mkv(JUNK,     1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mkv(JUNK,     1, 4'b0000, 8'h00, 1, 2, 0, 0, 0, 0, 0));
        vt.push_back(mkv(JUNK,     1, 4'b0010, 8'h00, 1, 2, 3, 0, 0, 0, 0));
        // LOAD r4,[5] with dm_ready low for 3 MEM cycles
        vt.push_back(mkv(16'h2405, 0, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv(JUNK,     1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv(JUNK,     0, 4'b0001, 8'h05, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv(JUNK,     0, 4'b0001, 8'h05, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv(JUNK,     0, 4'b0001, 8'h05, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv(JUNK,     1, 4'b0001, 8'h05, 0, 0, 0, 0, 0, 0, 1));
        vt.push_back(mkv(JUNK,     0, 4'b0010, 8'h00, 0, 0, 4, 0, 1, 0, 1));
        // STORE r5,[1]
        vt.push_back(mkv(16'h3501, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, 2));
        vt.push_back(mkv(JUNK,     0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, 2));
        vt.push_back(mkv(JUNK,     1, 4'b0001, 8'h01, 5, 0, 0, 0, 0, 1, 2));
        // JUMP 7
        vt.push_back(mkv(16'h4007, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, 3));
        vt.push_back(mkv(JUNK,     1, 4'b0100, 8'h07, 0, 0, 0, 0, 0, 0, 3));
        // NOP (undefined opcode 7)
        vt.push_back(mkv(16'h7ABC, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, 4));
        vt.push_back(mkv(JUNK,     1, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0, 4));
        // SUB r10 = r11 - r12
        vt.push_back(mkv(16'h1ABC, 1, 4'b1000, 8'h00, 0,   0,   0,   0, 0, 0, 5));
        vt.push_back(mkv(JUNK,     1, 4'b0000, 8'h00, 0,   0,   0,   0, 0, 0, 5));
        vt.push_back(mkv(JUNK,     1, 4'b0000, 8'h00, 11,  12,  0,   1, 0, 0, 5));
        vt.push_back(mkv(JUNK,     1, 4'b0010, 8'h00, 11,  12,  10,  1, 0, 0, 5));
        // JUMP 0 shows the SUB retired
        vt.push_back(mkv(16'h4000, 1, 4'b1000, 8'h00, 0, 0, 0, 0, 0, 0, 6));
        vt.push_back(mkv(JUNK,     1, 4'b0100, 8'h00, 0, 0, 0, 0, 0, 0, 6));

        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            instruction = vt[i].instr;
            dm_ready = vt[i].rdy;
            check_cycle(to_outs(vt[i]), $sformatf("vec%0d", i));
        end

        // Ten ADDs, then a LOAD interrupted by reset while stalled in MEM.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_instr({4'h0, 12'($urandom)}, 0);
        end
        instruction = 16'h2109;
        dm_ready = 1'b0;
        e = '0; e.pc_inc = 1'b1; e.ret = retv(10);
        check_cycle(e, "fetch_after_10_adds");
        instruction = JUNK;
        e = '0; e.ret = retv(10);
        check_cycle(e, "decode_load");
        e = '0; e.dm_req = 1'b1; e.dm_addr = 8'h09; e.ret = retv(10);
        check_cycle(e, "mem_stall0");
        #2;
        check_bit(dm_req, 1'b1, "dm_req_before_reset");
        reset = 1'b1;
        #1;
        check_cycle_now('0, "reset_mid_mem_outputs");
        check_bit(state_dbg == ST_FETCH, 1'b1, "reset_mid_mem_state");
        @(posedge clk);
        #1;
        check_cycle_now('0, "reset_held_outputs");
        reset = 1'b0;
        n_ret = 0;
        run_instr(16'h3501, 0);
        run_instr(16'h4007, 0);

        // HALT holds for 20 cycles with every enable low.
        run_instr(16'hF000, 20);
        do_reset();

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 19);
            case (pick)
                0, 1, 2, 3:   ins = {4'h0, 12'($urandom)};
                4, 5, 6:      ins = {4'h1, 12'($urandom)};
                7, 8, 9:      ins = {4'h2, 12'($urandom)};
                10, 11, 12:   ins = {4'h3, 12'($urandom)};
                13, 14, 15:   ins = {4'h4, 12'($urandom)};
                19:           ins = {4'hF, 12'($urandom)};
                default:      ins = {4'($urandom_range(5, 14)), 12'($urandom)};
            endcase
            run_instr(ins, 3);
            if (ins[15:12] == 4'hF) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 Parameter PC_W, default 8, program-counter/jump-target width.
REQ-002 Parameter DM_AW, default 8, data-memory address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction  input  16  current IM output at PC; opcode [15:12].
REQ-006 dm_ready  input  1  data-memory handshake completion.
REQ-007 pc_inc  output  1  one-cycle pulse: PC <= PC+1.
REQ-008 pc_load, pc_target  output  1, PC_W  load PC with pc_target.
REQ-009 rf_raddr1, rf_raddr2, rf_waddr  output  4 each  register-file addresses.
REQ-010 rf_we  output  1  register-file write enable.
REQ-011 wb_sel  output  1  0 = ALU result, 1 = DM read data.
REQ-012 alu_op  output  1  0 = ADD, 1 = SUB.
REQ-013 dm_req, dm_we, dm_addr  output  1, 1, DM_AW  data-memory request, write, address.
REQ-014 halted  output  1  high while in HALT.
REQ-015 retired_count  output  32  instructions completed.

Function
REQ-016 Formats: ADD 0000 / SUB 0001: rd[11:8], rs1[7:4], rs2[3:0]; LOAD 0010: rd[11:8], addr[7:0]; STORE 0011: rs[11:8], addr[7:0]; JUMP 0100: target[PC_W-1:0]; HALT 1111; all other opcodes NOP.
REQ-017 States: FETCH, DECODE, EXEC, MEM, WB, HALT; encoding one-hot or binary, implementer's choice.
REQ-018 FETCH: latch instruction into internal IR, assert pc_inc for exactly that cycle, go DECODE.
REQ-019 DECODE: ADD/SUB -> EXEC; LOAD/STORE -> MEM; JUMP -> pc_load=1, pc_target=IR target, -> FETCH; NOP -> FETCH; HALT -> HALT.
REQ-020 EXEC: drive rf_raddr1/2 = rs1/rs2, alu_op from opcode, -> WB.
REQ-021 WB: rf_we=1 for one cycle, rf_waddr=rd, rf_raddr1/2 and alu_op held from EXEC, wb_sel per opcode, -> FETCH.
REQ-022 MEM: dm_req=1, dm_addr=IR[7:0], dm_we=1 for STORE (rf_raddr1=rs), 0 for LOAD; stay until dm_ready sampled high; then LOAD -> WB (wb_sel=1), STORE -> FETCH.
REQ-023 dm_req, dm_we, dm_addr stable while waiting; dm_ready outside MEM ignored.
REQ-024 Latencies with dm_ready already high: ADD/SUB 4 cycles, LOAD 4, STORE 3, JUMP 2, NOP 2; each extra dm_ready-low cycle adds one.
REQ-025 HALT: all enables low, halted=1, exits only on reset.
REQ-026 pc_inc, pc_load, rf_we, dm_req never asserted except as stated; pc_inc and pc_load never in same cycle.
REQ-027 Instruction retires on the cycle leaving WB, MEM (STORE), or DECODE (JUMP/NOP); HALT does not retire.

Reset
REQ-028 reset asserted: state=FETCH, IR=0, all outputs 0, retired_count=0, immediately (asynchronous), including mid-MEM (dm_req drops without dm_ready).
REQ-029 First FETCH occurs on the first rising clk after reset deasserts.

Configuration
REQ-030 Macro CPU_CTRL_PERF_CNT_EN defined: retired_count increments by 1 per retire per REQ-027, saturating at 32'hFFFF_FFFF.
REQ-031 Macro undefined: retired_count tied to 0, no counter flops.

Structure
REQ-032 Package cpu_ctrl_pkg holds opcode constants, state encoding, alu_op and wb_sel encodings.
REQ-033 Combinational decoder sub-module cpu_ctrl_decode (IR -> opcode class, rd, rs1, rs2, addr, target); FSM in cpu_ctrl_fsm.

Verification
REQ-034 IR=16'h0312 (ADD r3=r1+r2), dm_ready=1 -> pc_inc cycle 1, rf_raddr1=1/rf_raddr2=2/alu_op=0 cycle 3, rf_we=1 rf_waddr=3 wb_sel=0 cycle 4.
REQ-035 IR=16'h2405 (LOAD r4,[5]), dm_ready low 3 cycles -> dm_req=1, dm_we=0, dm_addr=5 for 4 cycles, then rf_we=1, rf_waddr=4, wb_sel=1; 7 cycles total.
REQ-036 IR=16'h3501 (STORE r5,[1]), dm_ready=1 -> dm_req=1, dm_we=1, dm_addr=1, rf_raddr1=5 in cycle 3, no rf_we, back to FETCH.
REQ-037 IR=16'h4007 (JUMP 7) -> pc_inc cycle 1, pc_load=1 pc_target=7 cycle 2; IR=16'hF000 -> halted=1 held 20 cycles, no enables.
REQ-038 reset pulsed in MEM with dm_ready=0 -> dm_req=0 same time step, state FETCH, retired_count=0; with CPU_CTRL_PERF_CNT_EN, 10 ADDs -> retired_count=10.
